// File: rtl/cmd_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_word_assembler
//  Description : Packs five consecutive 16-bit host words into one 80-bit
//                command {TIME[31:0], DATA[15:0], ADDR[31:0]} and writes it
//                to the command FIFO. Resynchronises on start-of-frame and
//                discards stalled partial commands after an idle timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module cmd_word_assembler #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [79:0]       cmd_fifo_din,
  output logic              cmd_fifo_wr_en,
  input  logic              cmd_fifo_full,
  output logic              sync_err,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  cmd_count,
  output logic [CNT_W-1:0]  drop_count
);

  // The idle counter only needs to reach TIMEOUT_CYCLES-1; the terminal
  // edge itself performs the discard.
  localparam int                IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PUSH    = 1'b1
  } state_t;

  state_t            state_q;
  logic [2:0]        word_cnt_q;
  logic [79:0]       buf_q;
  logic [IDLE_W-1:0] idle_q;
  logic              ready_q;
  logic              wr_en_q;
  logic [79:0]       din_q;
  logic              sync_err_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  cmd_count_q;
  logic [CNT_W-1:0]  drop_count_q;

  logic              w_accept;

  // Ready is registered; reset masks it so no word is taken while rst is high.
  assign in_ready       = ready_q & ~rst;
  assign w_accept       = in_valid & in_ready;
  assign cmd_fifo_din   = din_q;
  assign cmd_fifo_wr_en = wr_en_q;
  assign sync_err       = sync_err_q;
  assign timeout_err    = timeout_err_q;
  assign cmd_count      = cmd_count_q;
  assign drop_count     = drop_count_q;

  // Collect/push state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      word_cnt_q    <= 3'd0;
      buf_q         <= 80'd0;
      idle_q        <= '0;
      ready_q       <= 1'b1;
      wr_en_q       <= 1'b0;
      din_q         <= 80'd0;
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cmd_count_q   <= '0;
      drop_count_q  <= '0;
    end else begin
      sync_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          ready_q <= 1'b1;
          if (w_accept) begin
            idle_q <= '0;
            if (in_sof && (word_cnt_q != 3'd0)) begin
              // Start-of-frame inside a partial command: drop it and restart.
              buf_q[79:64] <= in_data;
              word_cnt_q   <= 3'd1;
              sync_err_q   <= 1'b1;
              drop_count_q <= drop_count_q + CNT_ONE;
            end else if (word_cnt_q == 3'd4) begin
              buf_q[15:0] <= in_data;
              word_cnt_q  <= 3'd0;
              state_q     <= ST_PUSH;
              ready_q     <= 1'b0;
              // Write straight away when the FIFO has room so the strobe
              // lands in the cycle right after the last word.
              if (!cmd_fifo_full) begin
                wr_en_q     <= 1'b1;
                din_q       <= {buf_q[79:16], in_data};
                cmd_count_q <= cmd_count_q + CNT_ONE;
              end
            end else begin
              case (word_cnt_q)
                3'd0:    buf_q[79:64] <= in_data;
                3'd1:    buf_q[63:48] <= in_data;
                3'd2:    buf_q[47:32] <= in_data;
                3'd3:    buf_q[31:16] <= in_data;
                default: buf_q        <= buf_q;
              endcase
              word_cnt_q <= word_cnt_q + 3'd1;
            end
          end else if ((word_cnt_q != 3'd0) && (TIMEOUT_CYCLES != 0)) begin
            if (idle_q == IDLE_LAST) begin
              word_cnt_q    <= 3'd0;
              timeout_err_q <= 1'b1;
              drop_count_q  <= drop_count_q + CNT_ONE;
              idle_q        <= '0;
            end else begin
              idle_q <= idle_q + IDLE_ONE;
            end
          end else begin
            idle_q <= '0;
          end
        end
        ST_PUSH: begin
          if (wr_en_q) begin
            // Strobe has been presented for its single cycle.
            wr_en_q <= 1'b0;
            state_q <= ST_COLLECT;
            ready_q <= 1'b1;
          end else if (!cmd_fifo_full) begin
            wr_en_q     <= 1'b1;
            din_q       <= buf_q;
            cmd_count_q <= cmd_count_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_word_assembler
//  Description : Scoreboard bench for cmd_word_assembler with a queue-based
//                reference model of word framing, resync and timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmd_word_assembler;

  localparam int TO    = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic [79:0]      cmd_fifo_din;
  logic             cmd_fifo_wr_en;
  logic             cmd_fifo_full;
  logic             sync_err;
  logic             timeout_err;
  logic [CNT_W-1:0] cmd_count;
  logic [CNT_W-1:0] drop_count;

  cmd_word_assembler #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .cmd_fifo_din(cmd_fifo_din), .cmd_fifo_wr_en(cmd_fifo_wr_en),
    .cmd_fifo_full(cmd_fifo_full), .sync_err(sync_err), .timeout_err(timeout_err),
    .cmd_count(cmd_count), .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests  = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0]      part[$];
  logic [79:0]      sb[$];
  logic [79:0]      pending;
  logic [79:0]      exp_din;
  bit               busy, wrote, ready_m, exp_wr, exp_sync, exp_to, started;
  int               silent;
  logic [CNT_W-1:0] cmdc, dropc;

  initial begin
    started = 0; busy = 0; wrote = 0; ready_m = 0;
    exp_wr = 0; exp_sync = 0; exp_to = 0; silent = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      part.delete(); sb.delete();
      busy = 0; wrote = 0; ready_m = 1; silent = 0;
      exp_wr = 0; exp_sync = 0; exp_to = 0;
      cmdc = '0; dropc = '0; exp_din = '0;
      started = 1;
    end else if (started) begin
      exp_wr = 0; exp_sync = 0; exp_to = 0;
      if (busy) begin
        if (wrote) begin
          busy = 0; wrote = 0; ready_m = 1;
        end else if (!cmd_fifo_full) begin
          exp_wr = 1; wrote = 1; cmdc++; exp_din = pending; sb.push_back(pending);
        end
      end else if (in_valid && ready_m) begin
        silent = 0;
        if (in_sof && part.size() != 0) begin
          part.delete(); dropc++; exp_sync = 1;
        end
        part.push_back(in_data);
        if (part.size() == 5) begin
          pending = {part[0], part[1], part[2], part[3], part[4]};
          part.delete();
          busy = 1; ready_m = 0;
          if (!cmd_fifo_full) begin
            exp_wr = 1; wrote = 1; cmdc++; exp_din = pending; sb.push_back(pending);
          end
        end
      end else if (part.size() != 0) begin
        silent++;
        if (silent == TO) begin
          part.delete(); silent = 0; dropc++; exp_to = 1;
        end
      end
    end
  end

  // Per-cycle output checks against the model.
  always @(negedge clk) begin
    #1;
    if (started) begin
      check("in_ready", {79'd0, in_ready}, {79'd0, (rst ? 1'b0 : ready_m)});
      check("wr_en", {79'd0, cmd_fifo_wr_en}, {79'd0, exp_wr});
      check("din_hold", cmd_fifo_din, exp_din);
      check("sync_err", {79'd0, sync_err}, {79'd0, exp_sync});
      check("timeout_err", {79'd0, timeout_err}, {79'd0, exp_to});
      check("cmd_count", {{(80-CNT_W){1'b0}}, cmd_count}, {{(80-CNT_W){1'b0}}, cmdc});
      check("drop_count", {{(80-CNT_W){1'b0}}, drop_count}, {{(80-CNT_W){1'b0}}, dropc});
    end
  end

  // Scoreboard monitor: pops an expected command on every FIFO write.
  always @(negedge clk) begin
    logic [79:0] e;
    #1;
    if (started && cmd_fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", cmd_fifo_din, 80'hx);
      end else begin
        e = sb.pop_front();
        check("sb_cmd", cmd_fifo_din, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; holds the word until accepted, returns at a negedge.
  task automatic send(input logic [15:0] d, input logic s);
    int  n;
    bit  done;
    n = 0; done = 0;
    in_data = d; in_sof = s; in_valid = 1'b1;
    while (!done) begin
      @(posedge clk);
      if (in_ready) done = 1;
      else begin
        n++;
        if (n > 200) begin
          check("send_timeout", 80'd0, 80'd1);
          done = 1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; cmd_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Basic packing
    send(16'h0000, 1); send(16'h0064, 0); send(16'h00FF, 0); send(16'h0001, 0); send(16'h0002, 0);
    #1;
    check("basic_din", cmd_fifo_din, 80'h0000_0064_00FF_0001_0002);
    check("basic_wr", {79'd0, cmd_fifo_wr_en}, 80'd1);
    check("basic_count", {{(80-CNT_W){1'b0}}, cmd_count}, 80'd1);
    @(negedge clk);
    idle(2);

    // Back-pressure with a sixth word offered during the stall
    send(16'h1111, 1); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
    cmd_fifo_full = 1'b1;
    send(16'h5555, 0);
    in_data = 16'h6666; in_sof = 1'b1; in_valid = 1'b1;
    idle(10);
    cmd_fifo_full = 1'b0;
    send(16'h6666, 1); send(16'h7777, 0); send(16'h8888, 0); send(16'h9999, 0); send(16'hABCD, 0);
    idle(3);

    // SOF resync
    send(16'h0101, 1); send(16'h0202, 0); send(16'h0303, 0);
    send(16'hAAAA, 1); send(16'h0404, 0); send(16'h0505, 0); send(16'h0606, 0); send(16'h0707, 0);
    idle(3);

    // Timeout after silence, then a clean command
    send(16'hC001, 1); send(16'hC002, 0);
    idle(12);
    for (int i = 0; i < 5; i++) send(16'hD000 + 16'(i), (i == 0));
    idle(2);
    // Word arriving on the terminal cycle wins over the timeout
    send(16'hE001, 1); send(16'hE002, 0);
    idle(7);
    send(16'hE003, 0); send(16'hE004, 0); send(16'hE005, 0);
    idle(3);

    // Reset in the middle of a command
    send(16'hF001, 1); send(16'hF002, 0); send(16'hF003, 0); send(16'hF004, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h7000 + 16'(i), (i == 0));
    idle(3);

    // Streaming back-to-back, enough to wrap the counter
    for (int c = 0; c < 20; c++)
      for (int w = 0; w < 5; w++) send(16'($urandom), (w == 0));
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        in_valid = 1'b0;
        idle($urandom_range(6, 12));
      end
      in_valid      = ($urandom_range(0, 9) < 7);
      in_sof        = ($urandom_range(0, 9) == 0);
      in_data       = 16'($urandom);
      cmd_fifo_full = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; in_sof = 1'b0; cmd_fifo_full = 1'b0;
    idle(20);
    check("sb_empty", 80'(sb.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_word_assembler.md
Name: cmd_word_assembler

Overview:
- Upstream neighbour of the command scheduler.
- Accepts 16-bit words from the host-side bus interface (EBI/USB bridge), packs five consecutive words into one 80-bit command {TIME[31:0], DATA[15:0], ADDR[31:0]} and writes it into the command FIFO that the scheduler drains.
- Resynchronises framing on start-of-frame marks and discards stalled partial commands.

Parameters:
- TIMEOUT_CYCLES, 65535: cycles without a word, while a partial command is held, before that partial command is discarded. 0 disables the timeout.
- CNT_W, 16: width of the accepted and dropped command counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  16  host word
- in_valid  in  1  in_data is valid this cycle
- in_sof  in  1  qualifies in_data as word 0 of a command; meaningful only when in_valid=1
- in_ready  out  1  assembler can accept a word this cycle
- cmd_fifo_din  out  80  assembled command to the command FIFO
- cmd_fifo_wr_en  out  1  single-cycle FIFO write strobe
- cmd_fifo_full  in  1  command FIFO full
- sync_err  out  1  one-cycle pulse: partial command discarded because of SOF
- timeout_err  out  1  one-cycle pulse: partial command discarded because of timeout
- cmd_count  out  CNT_W  number of commands written to the FIFO; wraps
- drop_count  out  CNT_W  number of partial commands discarded; wraps

Behaviour:
- Reset values: in_ready=0 during reset and 1 from the first cycle after. cmd_fifo_wr_en=0, cmd_fifo_din=0, sync_err=0, timeout_err=0, cmd_count=0, drop_count=0, word_cnt=0, idle counter=0. Reset takes effect even in the middle of a command; no FIFO write is issued for discarded data.
- Word order:
  - word0 → din[79:64] (TIME high)
  - word1 → din[63:48] (TIME low)
  - word2 → din[47:32] (DATA)
  - word3 → din[31:16] (ADDR high)
  - word4 → din[15:0] (ADDR low)
- Accept means in_valid & in_ready on a rising edge of clk.
- States:
  - COLLECT: in_ready=1. Each accept stores the word at slot word_cnt and increments word_cnt. Accepting word4 moves to PUSH and resets word_cnt to 0.
  - PUSH: in_ready=0. If cmd_fifo_full=0, drive cmd_fifo_wr_en=1 for exactly one cycle with cmd_fifo_din stable and holding the full command, increment cmd_count, and return to COLLECT on the next cycle. If cmd_fifo_full=1, hold in PUSH indefinitely; there is no timeout in PUSH.
- Latency: word4 is accepted at edge N; cmd_fifo_wr_en is high in cycle N+1 when the FIFO is not full. Throughput is at most one command per 6 cycles.
- cmd_fifo_wr_en and cmd_fifo_din are registered outputs.
- cmd_fifo_din holds the last written value between writes. Slots of a partially received command are not visible on it.
- SOF handling:
  - SOF accepted with word_cnt=0: normal word0.
  - SOF accepted with word_cnt≠0: discard the partial command, pulse sync_err, increment drop_count, store the word as word0, word_cnt=1.
  - Non-SOF word accepted with word_cnt=0: taken as word0 (SOF is optional framing).
- Timeout:
  - An idle counter runs in COLLECT while word_cnt≠0 and no accept occurs. It clears on every accept and whenever word_cnt=0.
  - When it reaches TIMEOUT_CYCLES: word_cnt=0, pulse timeout_err, increment drop_count, clear the counter.
  - If an accept coincides with the terminal count, the accept wins and no timeout occurs.
- Counters wrap from 2^CNT_W−1 to 0. If sync_err and timeout_err would fire in the same cycle, sync_err wins and drop_count increments once.
- No combinational path from cmd_fifo_full to in_ready.

Test Plan:
- Basic packing: words 0x0000,0x0064,0x00FF,0x0001,0x0002 with in_sof on the first word, FIFO not full → one wr_en pulse one cycle after word4 with din=0x0000_0064_00FF_0001_0002; cmd_count=1.
- Back-pressure: cmd_fifo_full=1 before word4, released 10 cycles later → in_ready=0 throughout, wr_en exactly once on the first cycle with full=0, no word lost. Sixth word offered during the stall is accepted only after return to COLLECT.
- SOF resync: 3 words, then SOF word 0xAAAA followed by 4 more words → sync_err pulses once, drop_count=1, written din[79:64]=0xAAAA.
- Timeout: TIMEOUT_CYCLES=8, 2 words then silence → timeout_err exactly 8 cycles after the last accept, drop_count=1. Next 5 words form a correct command. Repeat with a word arriving on cycle 8 → no timeout.
- Reset mid-command: rst for 1 cycle after word3 → no wr_en, all counters 0, next 5 words assemble correctly.
- Streaming and wrap: 65537 back-to-back commands with CNT_W=16 → 65537 writes, no gaps beyond 6 cycles per command, cmd_count=1.
